// File: rtl/seg_bin2bcd_if.sv
// Request/result bundle between the CPU-side display register and the BCD converter.
interface seg_bin2bcd_if #(
  parameter int DATA_W = 20,
  parameter int DIGITS = 6
);
  logic                  start;
  logic [DATA_W-1:0]     bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  overflow;

  modport master (output start, bin_in, input busy, done, bcd_out, overflow);
  modport slave  (input start, bin_in, output busy, done, bcd_out, overflow);
endinterface

// File: rtl/seg_bin2bcd.sv
// Iterative double-dabble binary-to-BCD converter, one bit per clock.
// Result registers hold between conversions so the display scan can sample freely.
module seg_bin2bcd #(
  parameter int DATA_W  = 20,
  parameter int DIGITS  = 6,
  parameter int MAX_VAL = 999999
) (
  input  logic         clk,
  input  logic         resetn,
  seg_bin2bcd_if.slave bus
);
  localparam int CW = $clog2(DATA_W + 1);
  localparam int BW = 4 * DIGITS;

  function automatic logic [BW-1:0] f_bcd(input int v);
    logic [BW-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  localparam logic [DATA_W-1:0] MAX_B = DATA_W'(MAX_VAL);
  localparam logic [BW-1:0]     SAT_BCD = f_bcd(MAX_VAL);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_bin;
  logic [BW-1:0]     r_scr;
  logic [CW-1:0]     r_cnt;
  logic              r_ovf_pend;
  logic [BW-1:0]     r_bcd;
  logic              r_ovf;
  logic              r_done;

  logic [BW-1:0]     w_adj;
  logic [BW-1:0]     w_scr_nxt;
  logic [DATA_W-1:0] w_bin_nxt;
  logic              w_last;

  // Add-3 correction on every digit uses pre-shift values, all in parallel.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    assign w_adj[4*g +: 4] = (r_scr[4*g +: 4] >= 4'd5) ? r_scr[4*g +: 4] + 4'd3
                                                        : r_scr[4*g +: 4];
  end

  assign w_scr_nxt = {w_adj[BW-2:0], r_bin[DATA_W-1]};
  assign w_bin_nxt = {r_bin[DATA_W-2:0], 1'b0};
  assign w_last    = (r_state == SHIFT) && (r_cnt == CW'(DATA_W - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_nxt = SHIFT;
      SHIFT:   if (w_last)    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_bin      <= '0;
      r_scr      <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      r_bcd      <= '0;
      r_ovf      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (bus.start) begin
          r_bin      <= bus.bin_in;
          r_scr      <= '0;
          r_cnt      <= '0;
          r_ovf_pend <= (bus.bin_in > MAX_B);
        end
        SHIFT: begin
          r_scr <= w_scr_nxt;
          r_bin <= w_bin_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            // Truncated top digit is irrelevant: anything that large saturates.
            r_bcd  <= r_ovf_pend ? SAT_BCD : w_scr_nxt;
            r_ovf  <= r_ovf_pend;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (r_state == SHIFT);
  assign bus.done     = r_done;
  assign bus.bcd_out  = r_bcd;
  assign bus.overflow = r_ovf;
endmodule

// File: doc/seg_bin2bcd.md
Name: seg_bin2bcd

Overview:
- Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method.
- Sits directly upstream of the six-digit seven-segment display driver. It converts the 20-bit CPU-side display value into six packed BCD digits.
- This replaces the wide combinational divide/modulo chain with a 20-cycle iterative datapath.
- The converted result is held stable between conversions, so the display scan logic can sample it at any time.

Parameters:
- DATA_W, 20: width of the binary input. The iteration count equals DATA_W.
- DIGITS, 6: number of BCD output digits. bcd_out is 4*DIGITS bits wide.
- MAX_VAL, 999999: largest displayable value. Inputs above it saturate.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- start  input  1  conversion request; sampled only in IDLE.
- bin_in  input  DATA_W  binary value; captured on the edge that accepts start.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse; bcd_out and overflow are valid from this cycle.
- bcd_out  output  4*DIGITS  packed BCD result; digit 0 (ones) is in [3:0] and the most significant digit is in the top nibble.
- overflow  output  1  high when the last captured bin_in exceeded MAX_VAL.

Behaviour:
- Reset (resetn low, asynchronous): state=IDLE, busy=0, done=0, bcd_out=0, overflow=0, and all internal shift/scratch registers and the iteration counter are cleared.
- State machine has two states: IDLE and SHIFT.
- IDLE:
  - busy=0.
  - If start=1 at edge E0: capture bin_in into the binary shift register, clear the BCD scratch register and counter, register ovf_pending = (bin_in > MAX_VAL), set busy=1, and go to SHIFT.
- SHIFT: one iteration per edge, E1..E_DATA_W. Each iteration does the following:
  - Every scratch digit >= 5 gets +3. All digits are adjusted in parallel, using values from before the shift.
  - Then {scratch, binreg} is shifted left by 1.
  - The counter increments.
- Final iteration (edge E_DATA_W, E20 by default):
  - bcd_out is loaded with the post-shift scratch value, or with the BCD encoding of MAX_VAL (0x999999) if ovf_pending=1.
  - overflow is loaded with ovf_pending.
  - done is set to 1, busy is set to 0, and the state returns to IDLE.
- done is high for exactly one cycle (E20 to E21) and clears on the next edge.
- Latency: from the start-sampling edge to done rising is DATA_W edges. busy is high from E0 to E20.
- start while busy is ignored: no restart, and no capture of the new bin_in.
- start in the same cycle that done=1 is accepted, because the state is already IDLE. This allows back-to-back conversions with a 21-cycle period.
- bcd_out and overflow change only on a final-iteration edge or on reset. They hold their value indefinitely otherwise.
- bin_in changing during SHIFT has no effect.
- Reset asserted mid-conversion aborts immediately to the reset values. No done pulse is produced.
- No BCD digit may ever exceed 9 at any point.

Test Plan:
- Reset, then start with bin_in=0: done rises exactly 20 edges after the start edge, bcd_out=0x000000, overflow=0. busy must be high for exactly 20 cycles.
- bin_in=123456: bcd_out=0x123456. bin_in=999999: bcd_out=0x999999, overflow=0. bin_in=10: bcd_out=0x000010.
- bin_in=1048575 (0xFFFFF): bcd_out=0x999999, overflow=1. A following conversion of 42 gives 0x000042 and overflow=0.
- Start with 777; pulse start with 555 at cycles 5 and 19 while busy: a single done with bcd_out=0x000777. Then start asserted in the done cycle with 31415: second done exactly 20 edges later with 0x031415.
- Convert 654321, then assert resetn=0 at SHIFT cycle 10: outputs go to 0 immediately and no done appears. After release, converting 100000 gives 0x100000.
- Change bin_in every cycle during a conversion started with 2024: result is 0x002024, and bcd_out keeps its prior value until the done edge.
